// File: rtl/retry_pkg.sv
// rtl/retry_pkg.sv - shared types and helpers for the retry protocol endpoints
package retry_pkg;

   typedef logic [15:0] retry_cnt_t;

   localparam retry_cnt_t RetryCntMax = 16'hFFFF;

   function automatic int num_ids(input int id_size);
      return 1 << id_size;
   endfunction

endpackage

// File: rtl/retry_inorder_end.sv
// rtl/retry_inorder_end.sv - retry receiver: bounces failed IDs, releases clean results in ID order
module retry_inorder_end
   import retry_pkg::*;
#(
   parameter type DataType = logic [7:0],
   parameter int  IDSize   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  DataType           data_i,
   input  logic [IDSize-1:0] id_i,
   input  logic              needs_retry_i,
   input  logic              valid_i,
   output logic              ready_o,
   output DataType           data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [IDSize-1:0] retry_id_o,
   output logic              retry_valid_o,
   input  logic              retry_ready_i,
   output logic [15:0]       retry_cnt_o
);

   localparam int NumIds = num_ids(IDSize);

   DataType           data_q [NumIds];
   DataType           data_d [NumIds];
   logic [NumIds-1:0] occ_q, occ_d;
   logic [IDSize-1:0] next_id_q, next_id_d;
   logic              retry_pend_q, retry_pend_d;
   logic [IDSize-1:0] retry_id_q, retry_id_d;
   retry_cnt_t        retry_cnt_q, retry_cnt_d;

   logic up_fire;
   logic down_fire;
   logic retry_fire;

   // Upstream readiness looks only at registered occupancy, so a slot being
   // drained this cycle cannot be rewritten until the next one.
   assign ready_o       = !retry_pend_q && !occ_q[id_i];
   assign valid_o       = occ_q[next_id_q];
   assign data_o        = data_q[next_id_q];
   assign retry_valid_o = retry_pend_q;
   assign retry_id_o    = retry_id_q;
   assign retry_cnt_o   = retry_cnt_q;

   assign up_fire    = valid_i && ready_o;
   assign down_fire  = valid_o && ready_i;
   assign retry_fire = retry_pend_q && retry_ready_i;

   always_comb begin
      data_d       = data_q;
      occ_d        = occ_q;
      next_id_d    = next_id_q;
      retry_pend_d = retry_pend_q;
      retry_id_d   = retry_id_q;
      retry_cnt_d  = retry_cnt_q;

      if (down_fire) begin
         occ_d[next_id_q] = 1'b0;
         next_id_d        = next_id_q + 1'b1;
      end

      if (retry_fire) begin
         retry_pend_d = 1'b0;
         if (retry_cnt_q != RetryCntMax) begin
            retry_cnt_d = retry_cnt_q + 16'd1;
         end
      end

      if (up_fire) begin
         if (needs_retry_i) begin
            retry_pend_d = 1'b1;
            retry_id_d   = id_i;
         end else begin
            data_d[id_i] = data_i;
            occ_d[id_i]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumIds; i++) begin
            data_q[i] <= '0;
         end
         occ_q        <= '0;
         next_id_q    <= '0;
         retry_pend_q <= 1'b0;
         retry_id_q   <= '0;
         retry_cnt_q  <= '0;
      end else begin
         data_q       <= data_d;
         occ_q        <= occ_d;
         next_id_q    <= next_id_d;
         retry_pend_q <= retry_pend_d;
         retry_id_q   <= retry_id_d;
         retry_cnt_q  <= retry_cnt_d;
      end
   end

endmodule

// File: tb/tb_retry_inorder_end.sv
// tb/tb_retry_inorder_end.sv - directed vector bench for retry_inorder_end
module tb_retry_inorder_end;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [7:0]  data_i;
   logic [1:0]  id_i;
   logic        needs_retry_i;
   logic        valid_i;
   logic        ready_o;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic [1:0]  retry_id_o;
   logic        retry_valid_o;
   logic        retry_ready_i;
   logic [15:0] retry_cnt_o;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   retry_inorder_end #(
      .DataType (logic [7:0]),
      .IDSize   (2)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .data_i        (data_i),
      .id_i          (id_i),
      .needs_retry_i (needs_retry_i),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .retry_id_o    (retry_id_o),
      .retry_valid_o (retry_valid_o),
      .retry_ready_i (retry_ready_i),
      .retry_cnt_o   (retry_cnt_o)
   );

   typedef struct {
      bit         rst;
      bit         v;
      logic [1:0] id;
      logic [7:0] d;
      bit         nr;
      bit         rdy;
      bit         rrdy;
      bit         e_ready;
      bit         e_valid;
      logic [7:0] e_data;
      bit         e_rv;
      logic [1:0] e_rid;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit rst, input bit v, input logic [1:0] id, input logic [7:0] d,
                      input bit nr, input bit rdy, input bit rrdy, input bit e_ready,
                      input bit e_valid, input logic [7:0] e_data, input bit e_rv,
                      input logic [1:0] e_rid, input logic [15:0] e_cnt);
      vec_t r;
      r.rst = rst; r.v = v; r.id = id; r.d = d; r.nr = nr; r.rdy = rdy; r.rrdy = rrdy;
      r.e_ready = e_ready; r.e_valid = e_valid; r.e_data = e_data; r.e_rv = e_rv;
      r.e_rid = e_rid; r.e_cnt = e_cnt;
      vecs.push_back(r);
   endtask

   task automatic idle_inputs();
      valid_i       = 1'b0;
      id_i          = 2'd0;
      data_i        = 8'h00;
      needs_retry_i = 1'b0;
      ready_i       = 1'b0;
      retry_ready_i = 1'b0;
   endtask

   // Entered and left at a falling edge; reset spans exactly one rising edge.
   task automatic do_reset();
      rst_i = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic drive(input bit v, input logic [1:0] id, input logic [7:0] d, input bit nr,
                        input bit rdy, input bit rrdy);
      valid_i = v; id_i = id; data_i = d; needs_retry_i = nr;
      ready_i = rdy; retry_ready_i = rrdy;
   endtask

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      #1;
      chk("reset_ready", ready_o, 1);
      chk("reset_valid", valid_o, 0);
      chk("reset_data", data_o, 8'h00);
      chk("reset_rvalid", retry_valid_o, 0);
      chk("reset_rid", retry_id_o, 0);
      chk("reset_cnt", retry_cnt_o, 0);
      @(negedge clk);
      rst_i = 1'b0;

      // In-order clean stream: each result appears one cycle after acceptance.
      //  rst v  id    d      nr rdy rrdy eRdy eVal eData  eRv eRid eCnt
      add(0, 1, 2'd0, 8'hA0, 0, 1, 1,   1,   0,   8'h00, 0,  0,   16'd0);
      add(0, 1, 2'd1, 8'hA1, 0, 1, 1,   1,   1,   8'hA0, 0,  0,   16'd0);
      add(0, 1, 2'd2, 8'hA2, 0, 1, 1,   1,   1,   8'hA1, 0,  0,   16'd0);
      add(0, 1, 2'd3, 8'hA3, 0, 1, 1,   1,   1,   8'hA2, 0,  0,   16'd0);
      add(0, 1, 2'd0, 8'hA4, 0, 1, 1,   1,   1,   8'hA3, 0,  0,   16'd0);
      add(0, 0, 2'd0, 8'h00, 0, 1, 1,   0,   1,   8'hA4, 0,  0,   16'd0);
      add(0, 0, 2'd0, 8'h00, 0, 1, 1,   1,   0,   8'hA1, 0,  0,   16'd0);
      // Retry hold: ID0 bounced, IDs 1 and 2 held until the re-executed ID0 lands.
      add(1, 1, 2'd0, 8'h55, 1, 1, 1,   1,   0,   8'h00, 0,  0,   16'd0);
      add(0, 1, 2'd1, 8'h11, 0, 1, 1,   0,   0,   8'h00, 1,  0,   16'd0);
      add(0, 1, 2'd1, 8'h11, 0, 1, 1,   1,   0,   8'h00, 0,  0,   16'd1);
      add(0, 1, 2'd2, 8'h22, 0, 1, 1,   1,   0,   8'h00, 0,  0,   16'd1);
      add(0, 1, 2'd0, 8'h00, 0, 1, 1,   1,   0,   8'h00, 0,  0,   16'd1);
      add(0, 0, 2'd0, 8'h00, 0, 1, 1,   0,   1,   8'h00, 0,  0,   16'd1);
      add(0, 0, 2'd0, 8'h00, 0, 1, 1,   1,   1,   8'h11, 0,  0,   16'd1);
      add(0, 0, 2'd0, 8'h00, 0, 1, 1,   1,   1,   8'h22, 0,  0,   16'd1);
      add(0, 0, 2'd0, 8'h00, 0, 1, 1,   1,   0,   8'h00, 0,  0,   16'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) do_reset();
         drive(vecs[i].v, vecs[i].id, vecs[i].d, vecs[i].nr, vecs[i].rdy, vecs[i].rrdy);
         #1;
         chk($sformatf("vec%0d_ready", i), ready_o, vecs[i].e_ready);
         chk($sformatf("vec%0d_valid", i), valid_o, vecs[i].e_valid);
         chk($sformatf("vec%0d_data", i), data_o, vecs[i].e_data);
         chk($sformatf("vec%0d_rvalid", i), retry_valid_o, vecs[i].e_rv);
         chk($sformatf("vec%0d_rid", i), retry_id_o, vecs[i].e_rid);
         chk($sformatf("vec%0d_cnt", i), retry_cnt_o, vecs[i].e_cnt);
         @(negedge clk);
      end

      // Retry backpressure: upstream stalls while the retry source is busy.
      do_reset();
      drive(1, 2'd2, 8'h99, 1, 0, 0);
      @(negedge clk);
      drive(0, 2'd1, 8'h00, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("bp%0d_ready", i), ready_o, 0);
         chk($sformatf("bp%0d_rvalid", i), retry_valid_o, 1);
         chk($sformatf("bp%0d_rid", i), retry_id_o, 2'd2);
         @(negedge clk);
      end
      retry_ready_i = 1'b1;
      #1;
      chk("bp_hs_ready", ready_o, 0);
      @(negedge clk);
      retry_ready_i = 1'b0;
      #1;
      chk("bp_after_ready", ready_o, 1);
      chk("bp_after_rvalid", retry_valid_o, 0);
      chk("bp_after_cnt", retry_cnt_o, 16'd1);

      // Full table: every slot occupied blocks every ID.
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 2'(i), 8'h40 + 8'(i), 0, 0, 0);
         #1;
         chk($sformatf("full_wr%0d_ready", i), ready_o, 1);
         @(negedge clk);
      end
      drive(0, 2'd0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         id_i = 2'(i);
         #1;
         chk($sformatf("full_ready_id%0d", i), ready_o, 0);
      end
      chk("full_valid", valid_o, 1);
      chk("full_data", data_o, 8'h40);
      id_i    = 2'd0;
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      #1;
      chk("full_release_ready0", ready_o, 1);
      chk("full_release_data", data_o, 8'h41);
      id_i = 2'd1;
      #1;
      chk("full_release_ready1", ready_o, 0);

      // Wrap: eight results, pointer passes 3 -> 0 twice.
      @(negedge clk);
      do_reset();
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) drive(1, 2'(i % 4), 8'h80 + 8'(i), 0, 1, 0);
         else drive(0, 2'd0, 8'h00, 0, 1, 0);
         #1;
         if (i < 8) chk($sformatf("wrap%0d_ready", i), ready_o, 1);
         if (i > 0) begin
            chk($sformatf("wrap%0d_valid", i), valid_o, 1);
            chk($sformatf("wrap%0d_data", i), data_o, 8'h80 + 8'(i - 1));
         end
         @(negedge clk);
      end

      // Saturation from a preloaded counter.
      do_reset();
      force dut.retry_cnt_q = 16'hFFFE;
      #1;
      release dut.retry_cnt_q;
      #1;
      chk("sat_preload", retry_cnt_o, 16'hFFFE);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1, 2'd1, 8'h00, 1, 0, 1);
         @(negedge clk);
         drive(0, 2'd0, 8'h00, 0, 0, 1);
         @(negedge clk);
         #1;
         chk($sformatf("sat%0d_cnt", i), retry_cnt_o, 16'hFFFF);
      end

      // Async reset with stored results and a pending retry.
      do_reset();
      drive(1, 2'd3, 8'h00, 1, 0, 1);
      @(negedge clk);
      drive(0, 2'd0, 8'h00, 0, 0, 1);
      @(negedge clk);
      drive(1, 2'd0, 8'h5A, 0, 0, 0);
      @(negedge clk);
      drive(1, 2'd1, 8'h5B, 0, 0, 0);
      @(negedge clk);
      drive(1, 2'd2, 8'h00, 1, 0, 0);
      @(negedge clk);
      drive(0, 2'd0, 8'h00, 0, 0, 0);
      #1;
      chk("ar_pre_valid", valid_o, 1);
      chk("ar_pre_rvalid", retry_valid_o, 1);
      chk("ar_pre_cnt", retry_cnt_o, 16'd1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("ar_valid", valid_o, 0);
      chk("ar_rvalid", retry_valid_o, 0);
      chk("ar_cnt", retry_cnt_o, 16'd0);
      chk("ar_data", data_o, 8'h00);
      chk("ar_rid", retry_id_o, 2'd0);
      @(negedge clk);
      rst_i = 1'b0;
      drive(1, 2'd1, 8'h77, 0, 1, 0);
      #1;
      chk("ar_post_ready", ready_o, 1);
      @(negedge clk);
      drive(1, 2'd0, 8'h66, 0, 1, 0);
      #1;
      chk("ar_post_hold", valid_o, 0);
      @(negedge clk);
      drive(0, 2'd0, 8'h00, 0, 1, 0);
      #1;
      chk("ar_post_valid", valid_o, 1);
      chk("ar_post_data", data_o, 8'h66);
      @(negedge clk);
      #1;
      chk("ar_post_data2", data_o, 8'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
